// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Device clock falling edges per host-to-device frame, including the ACK edge.
    localparam int unsigned PS2_FRAME_EDGES = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge pulse.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_pipe;
    logic [1:0] data_pipe;
    logic       clk_prev;

    // Flops reset to the idle (released, pulled-up) line level so no edge is seen out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_pipe  <= {clk_pipe[0], ps2_clk};
            data_pipe <= {data_pipe[0], ps2_data};
            clk_prev  <= clk_pipe[1];
        end
    end

    assign clk_sync  = clk_pipe[1];
    assign data_sync = data_pipe[1];
    assign clk_fall  = clk_prev & ~clk_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe_out,
    output logic       ps2_data_oe_out,
    input  logic [7:0] data_in,
    input  logic       start_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       error_out
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       LAST_SHIFT = 4'(PS2_FRAME_EDGES - 1);

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk       (clk_in),
        .rst       (rst_in),
        .ps2_clk   (ps2_clk_in),
        .ps2_data  (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    state_t           state, state_d;
    logic [8:0]       shift_reg, shift_d;
    logic [3:0]       edge_cnt, edge_d;
    logic [INH_W-1:0] inh_cnt, inh_d;
    logic [TO_W-1:0]  to_cnt, to_d;
    logic             clk_oe, clk_oe_d;
    logic             data_oe, data_oe_d;
    logic             busy, busy_d;
    logic             done, done_d;
    logic             err, err_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            edge_cnt  <= '0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            clk_oe    <= 1'b0;
            data_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_d;
            edge_cnt  <= edge_d;
            inh_cnt   <= inh_d;
            to_cnt    <= to_d;
            clk_oe    <= clk_oe_d;
            data_oe   <= data_oe_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_reg;
        edge_d    = edge_cnt;
        inh_d     = inh_cnt;
        to_d      = (to_cnt == TO_LIMIT) ? to_cnt : to_cnt + 1'b1;
        data_oe_d = data_oe;

        case (state)
            ST_IDLE: begin
                to_d = '0;
                if (start_in) begin
                    shift_d = {odd_parity(data_in), data_in};
                    inh_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    edge_d  = '0;
                    to_d    = '0;
                    state_d = ST_REQ;
                end else begin
                    inh_d = inh_cnt + 1'b1;
                end
            end
            // Frame is shifted out LSB first with 1s filled in, so edge 10 releases the line as the stop bit.
            ST_REQ, ST_SHIFT: begin
                if (clk_fall) begin
                    edge_d    = edge_cnt + 4'd1;
                    to_d      = '0;
                    data_oe_d = ~shift_reg[0];
                    shift_d   = {1'b1, shift_reg[8:1]};
                    state_d   = (edge_cnt + 4'd1 == LAST_SHIFT) ? ST_ACK : ST_SHIFT;
                end else if (to_cnt == TO_LIMIT) begin
                    state_d = ST_FAIL;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    edge_d  = edge_cnt + 4'd1;
                    to_d    = '0;
                    state_d = data_sync ? ST_FAIL : ST_WAIT_IDLE;
                end else if (to_cnt == TO_LIMIT) begin
                    state_d = ST_FAIL;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_DONE;
                end else if (to_cnt == TO_LIMIT) begin
                    state_d = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase

        if (state_d == ST_REQ) begin
            data_oe_d = 1'b1;
        end else if (state_d != ST_SHIFT && state_d != ST_ACK) begin
            data_oe_d = 1'b0;
        end
        clk_oe_d = (state_d == ST_INHIBIT);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_FAIL);
    end

    assign ps2_clk_oe_out  = clk_oe;
    assign ps2_data_oe_out = data_oe;
    assign busy_out        = busy;
    assign done_out        = done;
    assign error_out       = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] data_in = '0;
    logic       start_in = 1'b0;
    logic       busy_out, done_out, error_out;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .ps2_clk_in      (ps2_clk),
        .ps2_data_in     (ps2_data),
        .ps2_clk_oe_out  (ps2_clk_oe),
        .ps2_data_oe_out (ps2_data_oe),
        .data_in         (data_in),
        .start_in        (start_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    typedef struct {
        logic [8:0] frame;
        bit         is_err;
        bit         chk_frame;
        int         lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_run = 0;

    int         dev_mode = 0;     // 0 ACK, 1 NACK, 2 silent
    bit         dev_abort = 0;
    bit         dev_active = 0;
    int         dev_bits = 0;
    logic [8:0] dev_frame = '0;
    logic       dev_stop = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Device: after the host releases the inhibit, clock out 11 pulses, sampling on rising edges.
    initial begin
        forever begin
            @(posedge ps2_clk_oe);
            @(negedge ps2_clk_oe);
            if (dev_mode == 2 || dev_abort) continue;
            dev_active = 1;
            dev_frame  = '0;
            dev_stop   = 1'b0;
            for (int i = 1; i <= 11; i++) begin
                repeat (HALF) @(negedge clk);
                if (dev_abort) break;
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                if (dev_abort) break;
                if (i <= 9) dev_frame[i-1] = ps2_data;
                else if (i == 10) dev_stop = ps2_data;
                dev_bits = i;
                if (i == 10 && dev_mode == 0) dev_data_low = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            dev_active   = 0;
        end
    end

    // Monitor: pop the expected outcome whenever done_out or error_out pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (done_out || error_out) begin
                check("done_error_exclusive", 32'(done_out & error_out), 0);
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, done_out, error_out}, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("pulse_kind", {30'b0, done_out, error_out}, mon_e.is_err ? 32'd1 : 32'd2);
                    if (mon_e.chk_frame) begin
                        check("wire_frame", 32'(dev_frame), 32'(mon_e.frame));
                        check("stop_bit", 32'(dev_stop), 1);
                    end
                    if (mon_e.lat >= 0)
                        check("timeout_latency_ok", 32'((cyc - start_cyc >= mon_e.lat - 3) && (cyc - start_cyc <= mon_e.lat + 3)), 1);
                    check("lines_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
                end
                if (done_out) done_cnt++;
                if (error_out) err_cnt++;
                @(negedge clk);
                check("busy_after_pulse", 32'(busy_out), 0);
            end
        end
    end

    // Inhibit length: count consecutive cycles with the clock enable asserted.
    initial begin
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                inh_run++;
            end else if (inh_run > 0) begin
                check("inhibit_len", 32'(inh_run), INH);
                inh_run = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [7:0] d, input int mode);
        dev_mode = mode;
        dev_bits = 0;
        @(negedge clk);
        data_in  = d;
        start_in = 1'b1;
        @(negedge clk);
        start_in  = 1'b0;
        start_cyc = cyc;
        check("busy_on_accept", 32'(busy_out), 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [8:0] frame, input int mode,
                        input bit is_err, input bit chk, input int lat);
        exp_t e;
        e.frame = frame;
        e.is_err = is_err;
        e.chk_frame = chk;
        e.lat = lat;
        q.push_back(e);
        issue(d, mode);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 4000 && (busy_out || dev_active || q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            total++;
            bad++;
            $display("FAIL %s_wait: busy=%0b queue=%0d after %0d cycles, required idle", name, busy_out, q.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic wait_bits(input int target);
        int n;
        n = 0;
        while (n < 2000 && dev_bits < target) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL wait_bits: got %0d device bits, required %0d", dev_bits, target);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_error", 32'(error_out), 0);
        rst = 1'b0;
        @(negedge clk);

        send(8'hED, 9'h1ED, 0, 0, 1, -1);
        wait_idle("ed");
        send(8'h07, 9'h007, 0, 0, 1, -1);
        wait_idle("07");
        send(8'h00, 9'h100, 0, 0, 1, -1);
        wait_idle("00");
        send(8'hFF, 9'h1FF, 1, 1, 1, -1);
        wait_idle("nack");
        send(8'hF4, 9'h0F4, 2, 1, 0, INH + TO);
        wait_idle("silent");

        // Second request while busy must be dropped.
        send(8'hF4, 9'h0F4, 0, 0, 1, -1);
        wait_bits(3);
        @(negedge clk);
        data_in  = 8'hAA;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        check("busy_during_ignored_start", 32'(busy_out), 1);
        wait_idle("f4");

        // Reset while the host drives data bit 3 (0 for 8'h52, so data_oe is asserted).
        issue(8'h52, 0);
        wait_bits(4);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        dev_abort = 1;
        #1;
        check("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("async_rst_data_oe", 32'(ps2_data_oe), 0);
        check("async_rst_busy", 32'(busy_out), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_idle("abort");
        dev_abort = 0;

        send(8'h3C, 9'h13C, 0, 0, 1, -1);
        wait_idle("3c");

        check("done_count", 32'(done_cnt), 5);
        check("error_count", 32'(err_cnt), 2);
        check("queue_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
